regbank_rr_arbiter: RTL and testbench

Round-robin arbiter and access sequencer for a shared bank of DEPTH WIDTH-bit flip-flop registers used as coefficient/state storage in the DSP datapath. Up to NREQ requesters contend for the bank. Each grant is a tenure of single-cycle read or write beats, capped at MAX_HOLD beats, after which ownership rotates. Read data is returned registered, tagged with the requester index.

---
 rtl/regbank_pkg.sv | 22 ++
 rtl/regbank_rr_pick.sv | 39 +++
 rtl/regbank_rr_arbiter.sv | 153 +++++++++++++++
 tb/tb_regbank_rr_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared definitions for the register-bank round-robin arbiter.
//   state_t  : FSM encoding (ST_IDLE = 0, ST_OWN = 1)
//   *_DEF    : default parameter values
//   clog2w() : clog2 clamped to at least 1 bit, for derived widths
package regbank_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  localparam int NREQ_DEF     = 4;
  localparam int WIDTH_DEF    = 16;
  localparam int DEPTH_DEF    = 8;
  localparam int MAX_HOLD_DEF = 4;

  // Keeps a 1-entry/1-requester corner from producing a zero-width vector.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regbank_rr_pick.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority index this round
//   any : at least one request is set
//   idx : first set request at or after ptr, wrapping modulo NREQ
// Implemented as rotate -> priority encode -> un-rotate.
module rr_pick
  import regbank_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IW   = clog2w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   idx
);

  logic [NREQ-1:0] rot;
  logic [IW-1:0]   src;
  logic [IW-1:0]   pos;

  always_comb begin
    rot = '0;
    src = '0;
    // rot[0] is the requester at ptr, so the lowest set bit wins.
    for (int i = 0; i < NREQ; i++) begin
      src    = IW'((i + int'(ptr)) % NREQ);
      rot[i] = req[src];
    end
    pos = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) pos = IW'(i);
    end
    any = |req;
    idx = IW'((int'(pos) + int'(ptr)) % NREQ);
  end

endmodule

// File: rtl/regbank_rr_arbiter.sv
// Round-robin arbiter and access sequencer for a shared flop register bank.
//   clk, rst_n : clock, async active-low reset (also clears the bank)
//   req        : per-requester level request
//   we         : per-requester write enable, sampled on beats
//   addr       : packed addresses, requester k at [k*AW +: AW]
//   wdata      : packed write data, requester k at [k*WIDTH +: WIDTH]
//   gnt        : registered one-hot grant, zero while idle
//   rdata/rid  : registered read data and the requester it belongs to
//   rvalid     : one-cycle pulse, cycle after a read beat
//   busy       : a tenure is in progress
// A tenure is up to MAX_HOLD single-cycle beats; ownership then rotates
// through a mandatory idle cycle.
module regbank_rr_arbiter
  import regbank_pkg::*;
#(
  parameter  int NREQ     = NREQ_DEF,
  parameter  int WIDTH    = WIDTH_DEF,
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  int MAX_HOLD = MAX_HOLD_DEF,
  localparam int AW       = clog2w(DEPTH),
  localparam int IW       = clog2w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid,
  output logic [IW-1:0]         rid,
  output logic                  busy
);

  localparam int            HW       = clog2w(MAX_HOLD + 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);
  localparam logic [HW-1:0] LAST_C   = HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] LAST_REQ = IW'(NREQ - 1);

  state_t        state, state_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [NREQ-1:0] gnt_nxt;

  logic          pick_any;
  logic [IW-1:0] pick_idx;

  logic [AW-1:0]    a_own;
  logic [WIDTH-1:0] wd_own;
  logic             we_own;
  logic             in_range;
  logic             beat;
  logic             rel;

  logic [DEPTH-1:0][WIDTH-1:0] bank;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Owner's request fields; everyone else is ignored.
  always_comb begin
    a_own  = '0;
    wd_own = '0;
    we_own = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (owner == IW'(k)) begin
        a_own  = addr[k*AW +: AW];
        wd_own = wdata[k*WIDTH +: WIDTH];
        we_own = we[k];
      end
    end
  end

  assign in_range = {1'b0, a_own} < DEPTH_C;
  assign beat     = (state == ST_OWN) && req[owner] && gnt[owner];
  // Release when the owner drops req, or on the beat that uses the last slot.
  assign rel      = (state == ST_OWN) && (!beat || (hold_cnt == LAST_C));
  assign busy     = (state == ST_OWN);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    gnt_nxt   = gnt;
    unique case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_nxt = ST_OWN;
          owner_nxt = pick_idx;
          hold_nxt  = '0;
          gnt_nxt   = NREQ'(1) << pick_idx;
        end
      end
      ST_OWN: begin
        if (beat) hold_nxt = hold_cnt + HW'(1);
        if (rel) begin
          state_nxt = ST_IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = (owner == LAST_REQ) ? '0 : owner + IW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
    end
  end

  // Out-of-range writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank <= '0;
    end else if (beat && we_own && in_range) begin
      bank[a_own] <= wd_own;
    end
  end

  // Out-of-range reads still pulse rvalid, with zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rid    <= '0;
    end else begin
      rvalid <= beat && !we_own;
      if (beat && !we_own) begin
        rdata <= in_range ? bank[a_own] : '0;
        rid   <= owner;
      end
    end
  end

endmodule

// File: tb/tb_regbank_rr_arbiter.sv
module tb_regbank_rr_arbiter;
  localparam int NREQ = 4, WIDTH = 16, DEPTH = 6, MAX_HOLD = 4;
  localparam int AW = 3, IW = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req, we;
  logic [NREQ*AW-1:0]    addr;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      rdata;
  logic                  rvalid;
  logic [IW-1:0]         rid;
  logic                  busy;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  regbank_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .rid(rid), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Tenure-level reference: who owns the bank, how many beats used, bank contents.
  int               m_owner, m_beats, m_ptr, m_k, m_a;
  logic [WIDTH-1:0] m_bank [DEPTH];
  logic [NREQ-1:0]  exp_gnt;
  logic             exp_rvalid;
  logic [WIDTH-1:0] exp_rdata;
  logic [IW-1:0]    exp_rid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_beats = 0; m_ptr = 0;
      for (int i = 0; i < DEPTH; i++) m_bank[i] = '0;
      exp_gnt = '0; exp_rvalid = 1'b0; exp_rdata = '0; exp_rid = '0;
    end else begin
      exp_rvalid = 1'b0;
      if (m_owner < 0) begin
        for (int n = 0; n < NREQ; n++) begin
          m_k = (m_ptr + n) % NREQ;
          if (req[m_k] && m_owner < 0) begin
            m_owner = m_k;
            m_beats = 0;
          end
        end
        if (m_owner >= 0) exp_gnt = NREQ'(1 << m_owner);
      end else if (req[m_owner]) begin
        m_a = int'(addr[m_owner*AW +: AW]);
        if (we[m_owner]) begin
          if (m_a < DEPTH) m_bank[m_a] = wdata[m_owner*WIDTH +: WIDTH];
        end else begin
          exp_rvalid = 1'b1;
          exp_rdata  = (m_a < DEPTH) ? m_bank[m_a] : '0;
          exp_rid    = IW'(m_owner);
        end
        m_beats++;
        if (m_beats == MAX_HOLD) begin
          exp_gnt = '0; m_ptr = (m_owner + 1) % NREQ; m_owner = -1;
        end
      end else begin
        exp_gnt = '0; m_ptr = (m_owner + 1) % NREQ; m_owner = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      chk("busy", 32'(busy), 32'(exp_gnt != '0));
      chk("rvalid", 32'(rvalid), 32'(exp_rvalid));
      chk("rdata", 32'(rdata), 32'(exp_rdata));
      chk("rid", 32'(rid), 32'(exp_rid));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int k, input logic w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    we[k] = w;
    addr[k*AW +: AW] = a;
    wdata[k*WIDTH +: WIDTH] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    do_reset();
    chk_en = 1'b1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", 32'(rdata), 0);

    // Read sweep of every address after reset; the model expects zeros.
    req = 4'b0001;
    for (int a = 0; a < 16; a++) begin
      drive(0, 1'b0, AW'(a % 8), '0);
      cyc(1);
    end
    req = '0;
    cyc(2);

    // Round robin from ptr=0 with all requesters held.
    do_reset();
    for (int k = 0; k < NREQ; k++) drive(k, 1'b0, AW'(k), '0);
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        cyc(1);
        chk("rr_gnt", 32'(gnt), 32'(1 << (t % 4)));
      end
      cyc(1);
      chk("rr_gap", 32'(gnt), 0);
    end
    req = '0;
    cyc(2);

    // Write then read of the same address by requester 1 (ptr is 1 here).
    drive(1, 1'b1, 3'd3, 16'h00A5);
    req = 4'b0010;
    cyc(1); chk("wr_gnt", 32'(gnt), 32'b0010);
    cyc(1); we[1] = 1'b0;
    cyc(1);
    chk("rd_rvalid", 32'(rvalid), 1);
    chk("rd_rdata", 32'(rdata), 32'h00A5);
    chk("rd_rid", 32'(rid), 1);
    req = '0;
    cyc(2);

    // Early release by requester 2 after two beats; next grant goes to 3.
    drive(0, 1'b0, 3'd3, '0); drive(2, 1'b0, 3'd3, '0); drive(3, 1'b0, 3'd3, '0);
    req = 4'b0100;
    cyc(1); chk("er_gnt0", 32'(gnt), 32'b0100);
    cyc(1); chk("er_gnt1", 32'(gnt), 32'b0100);
    cyc(1); chk("er_gnt2", 32'(gnt), 32'b0100);
    req = 4'b1001;
    cyc(1); chk("er_drop", 32'(gnt), 0);
    cyc(1); chk("er_next", 32'(gnt), 32'b1000);
    req = '0;
    cyc(3);

    // Out-of-range write then read by requester 0.
    drive(0, 1'b1, 3'd7, 16'h1234);
    req = 4'b0001;
    cyc(1); chk("oor_gnt", 32'(gnt), 32'b0001);
    cyc(1); we[0] = 1'b0;
    cyc(1);
    chk("oor_rvalid", 32'(rvalid), 1);
    chk("oor_rdata", 32'(rdata), 0);
    req = '0;
    cyc(2);

    // Reset in the middle of a write beat by requester 2 (ptr is 1 here).
    drive(2, 1'b1, 3'd5, 16'hBEEF);
    req = 4'b0100;
    cyc(1); chk("mid_gnt", 32'(gnt), 32'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    cyc(1);
    rst_n = 1'b1;
    drive(0, 1'b0, 3'd5, '0); drive(2, 1'b0, 3'd5, '0);
    req = 4'b0101;
    cyc(1); chk("post_rst_gnt", 32'(gnt), 32'b0001);
    cyc(1);
    chk("post_rst_rvalid", 32'(rvalid), 1);
    chk("post_rst_rdata", 32'(rdata), 0);
    req = '0;
    cyc(2);

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      for (int k = 0; k < NREQ; k++) begin
        if ($urandom_range(0, 3) == 0) req[k] = ~req[k];
        drive(k, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), WIDTH'($urandom));
      end
      cyc(1);
    end
    req = '0;
    cyc(3);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
